// File: rtl/vga_pkg.sv
// Shared definitions for the VGA raster timing generator: axis state encoding,
// default 800x480 timing constants and total-length derivation.
package vga_pkg;

  localparam int CNT_W = 11;

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    FRONT  = 2'd1,
    SYNC   = 2'd2,
    BACK   = 2'd3
  } axis_state_t;

  localparam int DEF_H_ACTIVE = 800;
  localparam int DEF_H_FP     = 40;
  localparam int DEF_H_SYNC   = 48;
  localparam int DEF_H_BP     = 88;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 13;
  localparam int DEF_V_SYNC   = 3;
  localparam int DEF_V_BP     = 32;

  function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  localparam int DEF_H_TOTAL = axis_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
  localparam int DEF_V_TOTAL = axis_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter with an ACTIVE/FRONT/SYNC/BACK state machine,
// raw sync/active decode and a wrap strobe for cascading into the next axis.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int SEG_ACTIVE = DEF_H_ACTIVE,
  parameter int SEG_FP     = DEF_H_FP,
  parameter int SEG_SYNC   = DEF_H_SYNC,
  parameter int SEG_BP     = DEF_H_BP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             advance,
  output logic [CNT_W-1:0] count,
  output logic             wrap,
  output logic             sync_raw,
  output logic             active_raw
);

  localparam int TOTAL = axis_total(SEG_ACTIVE, SEG_FP, SEG_SYNC, SEG_BP);
  localparam logic [CNT_W-1:0] END_ACTIVE = CNT_W'(SEG_ACTIVE - 1);
  localparam logic [CNT_W-1:0] END_FRONT  = CNT_W'(SEG_ACTIVE + SEG_FP - 1);
  localparam logic [CNT_W-1:0] END_SYNC   = CNT_W'(SEG_ACTIVE + SEG_FP + SEG_SYNC - 1);
  localparam logic [CNT_W-1:0] END_BACK   = CNT_W'(TOTAL - 1);

  axis_state_t      state_reg, state_next;
  logic [CNT_W-1:0] count_reg, count_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ACTIVE;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
    end
  end

  // The state always names the region that count_reg currently sits in.
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    wrap       = 1'b0;
    if (advance) begin
      count_next = count_reg + 1'b1;
      case (state_reg)
        ACTIVE: if (count_reg == END_ACTIVE) state_next = FRONT;
        FRONT:  if (count_reg == END_FRONT)  state_next = SYNC;
        SYNC:   if (count_reg == END_SYNC)   state_next = BACK;
        BACK: begin
          if (count_reg == END_BACK) begin
            state_next = ACTIVE;
            count_next = '0;
            wrap       = 1'b1;
          end
        end
        default: state_next = ACTIVE;
      endcase
    end
  end

  assign count      = count_reg;
  assign sync_raw   = (state_reg == SYNC);
  assign active_raw = (state_reg == ACTIVE);

endmodule

// File: rtl/vga_timing.sv
// 800x480 VGA raster timing: pixel counters plus hsync/vsync/de delayed to match
// frame-buffer read latency. Optional frame counter under VGA_TIMING_FRAME_CNT_EN.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int H_FP       = DEF_H_FP,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BP       = DEF_H_BP,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int V_FP       = DEF_V_FP,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BP       = DEF_V_BP,
  parameter bit HSYNC_POL  = 1'b0,
  parameter bit VSYNC_POL  = 1'b0,
  parameter int PIPE_DELAY = 1
) (
  input  logic             clk,
  input  logic             reset,
  output logic [CNT_W-1:0] vga_h,
  output logic [CNT_W-1:0] vga_v,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic             line_start,
`ifdef VGA_TIMING_FRAME_CNT_EN
  output logic             frame_start,
  output logic [15:0]      frame_count
`else
  output logic             frame_start
`endif
);

  logic       run_reg;
  logic       h_wrap, h_sync, h_active;
  logic       v_wrap, v_sync, v_active;
  logic       line_start_reg, frame_start_reg;
  logic [2:0] raw_sigs;
  logic [2:0] dly_out;

  // Counters hold for one clock after reset release so (0,0) is presented with the strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) run_reg <= 1'b0;
    else       run_reg <= 1'b1;
  end

  vga_axis_counter #(
    .SEG_ACTIVE(H_ACTIVE), .SEG_FP(H_FP), .SEG_SYNC(H_SYNC), .SEG_BP(H_BP)
  ) u_h_axis (
    .clk(clk), .reset(reset), .advance(run_reg),
    .count(vga_h), .wrap(h_wrap), .sync_raw(h_sync), .active_raw(h_active)
  );

  vga_axis_counter #(
    .SEG_ACTIVE(V_ACTIVE), .SEG_FP(V_FP), .SEG_SYNC(V_SYNC), .SEG_BP(V_BP)
  ) u_v_axis (
    .clk(clk), .reset(reset), .advance(h_wrap),
    .count(vga_v), .wrap(v_wrap), .sync_raw(v_sync), .active_raw(v_active)
  );

  // Strobes are registered from the wrap that brings the counters to zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      line_start_reg  <= 1'b0;
      frame_start_reg <= 1'b0;
    end else begin
      line_start_reg  <= !run_reg || h_wrap;
      frame_start_reg <= !run_reg || v_wrap;
    end
  end

  assign line_start  = line_start_reg;
  assign frame_start = frame_start_reg;

  assign raw_sigs = run_reg ? {h_sync, v_sync, h_active & v_active} : 3'b000;

  generate
    if (PIPE_DELAY == 0) begin : g_nodly
      assign dly_out = raw_sigs;
    end else begin : g_dly
      logic [2:0] stage_reg [PIPE_DELAY];
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < PIPE_DELAY; i++) stage_reg[i] <= 3'b000;
        end else begin
          stage_reg[0] <= raw_sigs;
          for (int i = 1; i < PIPE_DELAY; i++) stage_reg[i] <= stage_reg[i-1];
        end
      end
      assign dly_out = stage_reg[PIPE_DELAY-1];
    end
  endgenerate

  assign hsync = HSYNC_POL ? dly_out[2] : !dly_out[2];
  assign vsync = VSYNC_POL ? dly_out[1] : !dly_out[1];
  assign de    = dly_out[0];

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] frame_count_reg;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       frame_count_reg <= '0;
    else if (v_wrap) frame_count_reg <= frame_count_reg + 16'd1;
  end
  assign frame_count = frame_count_reg;
`endif

endmodule

// File: tb/tb_vga_timing.sv
// Self-checking bench for vga_timing on a shrunken raster, three builds
// (PIPE_DELAY 1/0/3, mixed polarities) against an arithmetic reference model.
module tb_vga_timing;

  localparam int HA = 16, HF = 4, HS = 5, HB = 3;
  localparam int VA = 10, VF = 2, VS = 3, VB = 2;
  localparam int HT = HA + HF + HS + HB;   // 28
  localparam int VT = VA + VF + VS + VB;   // 17
  localparam int FT = HT * VT;             // 476
  localparam int NDUT = 3;

  function automatic int dly_of(input int i);
    case (i)
      0: return 1;
      1: return 0;
      default: return 3;
    endcase
  endfunction
  function automatic bit hpol_of(input int i);
    return (i != 0);
  endfunction
  function automatic bit vpol_of(input int i);
    return (i == 1);
  endfunction

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [NDUT-1:0][10:0] vh, vv;
  logic [NDUT-1:0] hs, vs, de, ls, fs;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [NDUT-1:0][15:0] fc;
`endif

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
    vga_timing #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .HSYNC_POL(hpol_of(gi)), .VSYNC_POL(vpol_of(gi)), .PIPE_DELAY(dly_of(gi))
    ) u_dut (
      .clk(clk), .reset(reset),
      .vga_h(vh[gi]), .vga_v(vv[gi]),
      .hsync(hs[gi]), .vsync(vs[gi]), .de(de[gi]),
      .line_start(ls[gi]),
`ifdef VGA_TIMING_FRAME_CNT_EN
      .frame_start(fs[gi]),
      .frame_count(fc[gi])
`else
      .frame_start(fs[gi])
`endif
    );
  end

  typedef struct packed {
    logic [10:0] h;
    logic [10:0] v;
    logic hs, vs, de, ls, fs;
    logic [15:0] fc;
  } obs_t;

  typedef struct {
    int k;
    int h, v;
    bit hs, vs, de, ls, fs;
  } vec_t;

  int k = -1;      // pixel clocks since the counters started running; -1 = held in reset
  int n_cmp = 0;
  int n_bad = 0;

  // Reference: raster position is plain arithmetic on elapsed clocks; syncs are
  // the same arithmetic looked up dly clocks in the past.
  function automatic obs_t model(input int idx, input int kk);
    obs_t o;
    int p, j, rh, rv;
    bit r_hs, r_vs, r_de;
    o = '0;
    r_hs = 0; r_vs = 0; r_de = 0;
    if (kk >= 0) begin
      p = kk % FT;
      o.h = 11'(p % HT);
      o.v = 11'(p / HT);
      o.ls = ((p % HT) == 0);
      o.fs = (p == 0);
`ifdef VGA_TIMING_FRAME_CNT_EN
      o.fc = 16'(kk / FT);
`endif
      j = kk - dly_of(idx);
      if (j >= 0) begin
        p = j % FT;
        rh = p % HT;
        rv = p / HT;
        r_de = (rh < HA) && (rv < VA);
        r_hs = (rh >= HA + HF) && (rh < HA + HF + HS);
        r_vs = (rv >= VA + VF) && (rv < VA + VF + VS);
      end
    end
    o.hs = hpol_of(idx) ? r_hs : !r_hs;
    o.vs = vpol_of(idx) ? r_vs : !r_vs;
    o.de = r_de;
    return o;
  endfunction

  function automatic obs_t sample(input int idx);
    obs_t o;
    o = '0;
    o.h = vh[idx]; o.v = vv[idx];
    o.hs = hs[idx]; o.vs = vs[idx]; o.de = de[idx];
    o.ls = ls[idx]; o.fs = fs[idx];
`ifdef VGA_TIMING_FRAME_CNT_EN
    o.fc = fc[idx];
`endif
    return o;
  endfunction

  task automatic check_all(input string name);
    obs_t got, exp;
    for (int i = 0; i < NDUT; i++) begin
      got = sample(i);
      exp = model(i, k);
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL %s dut%0d k=%0d got h=%0d v=%0d hs=%b vs=%b de=%b ls=%b fs=%b fc=%0d want h=%0d v=%0d hs=%b vs=%b de=%b ls=%b fs=%b fc=%0d",
                 name, i, k, got.h, got.v, got.hs, got.vs, got.de, got.ls, got.fs, got.fc,
                 exp.h, exp.v, exp.hs, exp.vs, exp.de, exp.ls, exp.fs, exp.fc);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (reset) k = -1;
    else k = k + 1;
    @(negedge clk);
  endtask

  task automatic check_vec(input vec_t t);
    logic [26:0] got, exp;
    got = {vh[0], vv[0], hs[0], vs[0], de[0], ls[0], fs[0]};
    exp = {11'(t.h), 11'(t.v), t.hs, t.vs, t.de, t.ls, t.fs};
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL table k=%0d got h=%0d v=%0d hs/vs/de/ls/fs=%b want h=%0d v=%0d hs/vs/de/ls/fs=%b",
               t.k, got[26:16], got[15:5], got[4:0], t.h, t.v, exp[4:0]);
    end
    $display("table k=%0d h=%0d v=%0d hs=%b vs=%b de=%b ls=%b fs=%b", t.k, vh[0], vv[0], hs[0], vs[0], de[0], ls[0], fs[0]);
  endtask

  task automatic async_reset_check(input string name);
    #3;
    reset = 1'b1;
    #1;
    k = -1;
    check_all(name);
  endtask

  vec_t tab[$];
  int   last_fs, period, budget;
  bit   seen;

  initial begin
    // Hand-computed points for dut0 (PIPE_DELAY=1, active-low syncs) on the 28x17 raster.
    tab = '{
      '{-1,  0,  0, 1, 1, 0, 0, 0},
      '{ 0,  0,  0, 1, 1, 0, 1, 1},
      '{ 1,  1,  0, 1, 1, 1, 0, 0},
      '{16, 16,  0, 1, 1, 1, 0, 0},
      '{17, 17,  0, 1, 1, 0, 0, 0},
      '{20, 20,  0, 1, 1, 0, 0, 0},
      '{21, 21,  0, 0, 1, 0, 0, 0},
      '{25, 25,  0, 0, 1, 0, 0, 0},
      '{26, 26,  0, 1, 1, 0, 0, 0},
      '{27, 27,  0, 1, 1, 0, 0, 0},
      '{28,  0,  1, 1, 1, 0, 1, 0},
      '{29,  1,  1, 1, 1, 1, 0, 0},
      '{253, 1,  9, 1, 1, 1, 0, 0},
      '{281, 1, 10, 1, 1, 0, 0, 0},
      '{336, 0, 12, 1, 1, 0, 1, 0},
      '{337, 1, 12, 1, 0, 0, 0, 0},
      '{420, 0, 15, 1, 0, 0, 1, 0},
      '{421, 1, 15, 1, 1, 0, 0, 0},
      '{475, 27, 16, 1, 1, 0, 0, 0},
      '{476, 0,  0, 1, 1, 0, 1, 1},
      '{477, 1,  0, 1, 1, 1, 0, 0}
    };

    reset = 1'b1;
    repeat (3) step();
    check_all("reset");
    check_vec(tab[0]);
    reset = 1'b0;

    for (int i = 1; i < tab.size(); i++) begin
      while (k < tab[i].k) begin
        step();
        check_all("run");
      end
      check_vec(tab[i]);
    end

    // Reset in the middle of both sync pulses must clear outputs without a clock edge.
    while (k < FT + 13 * HT + 23) begin
      step();
      check_all("pre_midreset");
    end
    n_cmp++;
    if (hs[0] !== 1'b0 || vs[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL midreset_setup got hs=%b vs=%b want 0 0", hs[0], vs[0]);
    end
    async_reset_check("midreset_async");
    $display("midreset hs=%b vs=%b de=%b h=%0d v=%0d", hs[0], vs[0], de[0], vh[0], vv[0]);
    step();
    check_all("midreset_hold");
    reset = 1'b0;
    step();
    check_all("restart");

    // Measure frame_start period on dut0, with a bounded wait.
    last_fs = -1; period = -1; seen = 0; budget = 0;
    while (period < 0 && budget < 3 * FT) begin
      step();
      check_all("period_run");
      budget++;
      if (fs[0] === 1'b1) begin
        if (seen) period = k - last_fs;
        last_fs = k;
        seen = 1;
      end
    end
    n_cmp++;
    if (period != FT) begin
      n_bad++;
      $display("FAIL frame_period got %0d want %0d", period, FT);
    end
    $display("frame_start period=%0d", period);

`ifdef VGA_TIMING_FRAME_CNT_EN
    async_reset_check("fc_reset");
    step();
    reset = 1'b0;
    while (k < 3 * FT) begin
      step();
      check_all("fc_run");
    end
    n_cmp++;
    if (fc[0] !== 16'd3) begin
      n_bad++;
      $display("FAIL frame_count3 got %0d want 3", fc[0]);
    end
    $display("frame_count after 3 frames=%0d", fc[0]);
`endif

    // Randomised run with sporadic asynchronous resets of random length.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 399) == 0) begin
        async_reset_check("rand_async");
        repeat ($urandom_range(1, 3)) begin
          step();
          check_all("rand_hold");
        end
        reset = 1'b0;
      end
      step();
      check_all("rand_run");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
